streak_tracker: RTL



---
 rtl/streak_tracker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/streak_tracker.sv
// streak_tracker: streak engine for the dance game scoring path.
// Turns per-step hit/miss judgements into a current streak, a best streak,
// a score multiplier tier and one-cycle milestone/broken pulses. All outputs
// are registered and reflect the event sampled on the previous clock edge.
// Optional build macro STREAK_GRACE_EN adds a GRACE state. In that state the
// first miss on a long streak costs one multiplier tier instead of the streak.
module streak_tracker #(
   parameter int WIDTH     = 16,
   parameter int TIER_STEP = 10,
   parameter int MAX_MULT  = 4,
   parameter int MILESTONE = 25,
   localparam int MW       = $clog2(MAX_MULT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             hit_valid,
   input  logic             miss_valid,
   output logic [WIDTH-1:0] streak_out,
   output logic [WIDTH-1:0] best_out,
   output logic [MW-1:0]    mult_out,
   output logic             milestone_pulse,
   output logic             broken_pulse
);

   // Arithmetic width wide enough for both the streak and the integer parameters.
   localparam int CW = (WIDTH > 32) ? WIDTH : 32;
   localparam logic [WIDTH-1:0] STREAK_MAX = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACTIVE    = 2'd1,
      SATURATED = 2'd2
`ifdef STREAK_GRACE_EN
      , GRACE   = 2'd3
`endif
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] streak_next;
   logic [WIDTH-1:0] best_next;
   logic [MW-1:0]    mult_next;
   logic             milestone_next;
   logic             broken_next;

   // Multiplier tier for a given streak: 1 + streak / TIER_STEP, capped at MAX_MULT.
   function automatic logic [MW-1:0] mult_of(input logic [WIDTH-1:0] s);
      logic [CW-1:0] tier;
      tier = CW'(s) / CW'(TIER_STEP);
      if (tier >= CW'(MAX_MULT - 1))
         mult_of = MW'(MAX_MULT);
      else
         mult_of = MW'(tier + 1'b1);
   endfunction

   // True when the streak sits on a multiple of MILESTONE.
   function automatic logic on_milestone(input logic [WIDTH-1:0] s);
      on_milestone = ((CW'(s) % CW'(MILESTONE)) == '0);
   endfunction

   // Next-state and next-output decode, in the order clear > miss > hit.
   always_comb begin
      state_next     = state;
      streak_next    = streak_out;
      mult_next      = mult_out;
      milestone_next = 1'b0;
      broken_next    = 1'b0;

      if (clear) begin
         state_next  = IDLE;
         streak_next = '0;
         mult_next   = MW'(1);
      end else if (miss_valid) begin
         case (state)
            IDLE: begin
               // Nothing to break: the streak is already zero.
               state_next = IDLE;
            end
            ACTIVE, SATURATED: begin
`ifdef STREAK_GRACE_EN
               if (CW'(streak_out) >= CW'(TIER_STEP)) begin
                  // First miss on a long streak: keep the streak, lose a tier.
                  state_next = GRACE;
                  mult_next  = (mult_out > MW'(1)) ? mult_out - MW'(1) : MW'(1);
               end else begin
                  state_next  = IDLE;
                  streak_next = '0;
                  mult_next   = MW'(1);
                  broken_next = 1'b1;
               end
`else
               state_next  = IDLE;
               streak_next = '0;
               mult_next   = MW'(1);
               broken_next = 1'b1;
`endif
            end
`ifdef STREAK_GRACE_EN
            GRACE: begin
               // Second miss in a row: the grace is used up.
               state_next  = IDLE;
               streak_next = '0;
               mult_next   = MW'(1);
               broken_next = 1'b1;
            end
`endif
            default: begin
               state_next  = IDLE;
               streak_next = '0;
               mult_next   = MW'(1);
            end
         endcase
      end else if (hit_valid) begin
         if (streak_out == STREAK_MAX) begin
            // Pinned at the top: hold the count, never re-fire the milestone.
            state_next  = SATURATED;
            streak_next = streak_out;
            mult_next   = mult_of(streak_out);
         end else begin
            streak_next    = streak_out + 1'b1;
            state_next     = (streak_next == STREAK_MAX) ? SATURATED : ACTIVE;
            mult_next      = mult_of(streak_next);
            milestone_next = on_milestone(streak_next);
         end
      end

      // Best follows the new streak in the same cycle, so it never lags.
      best_next = (streak_next > best_out) ? streak_next : best_out;
   end

   // State and all outputs registered together; reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         streak_out      <= '0;
         best_out        <= '0;
         mult_out        <= MW'(1);
         milestone_pulse <= 1'b0;
         broken_pulse    <= 1'b0;
      end else begin
         state           <= state_next;
         streak_out      <= streak_next;
         best_out        <= best_next;
         mult_out        <= mult_next;
         milestone_pulse <= milestone_next;
         broken_pulse    <= broken_next;
      end
   end

endmodule
